// File: rtl/div_color_cfg_ctrl_pkg.sv
// Shared definitions for the div_color threshold controller: host address map,
// calibration FSM states and small address-decode helpers.
package div_color_cfg_ctrl_pkg;

    localparam int CFG_ADDR_W = 3;

    localparam logic [CFG_ADDR_W-1:0] ADDR_R0     = 3'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_G0     = 3'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_B0     = 3'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_ERR    = 3'd3;
    localparam logic [CFG_ADDR_W-1:0] ADDR_VMIN   = 3'd4;
    localparam logic [CFG_ADDR_W-1:0] ADDR_VMAX   = 3'd5;
    localparam logic [CFG_ADDR_W-1:0] ADDR_COMMIT = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAL_WAIT = 2'd1,
        ST_CAL_ACC  = 2'd2,
        ST_CAL_WR   = 2'd3
    } cal_state_e;

    function automatic logic is_commit_addr(input logic [CFG_ADDR_W-1:0] addr);
        return (addr == ADDR_COMMIT);
    endfunction

endpackage

// File: rtl/div_color_cal_acc.sv
// Calibration accumulator: sums in-window R/G/B samples, counts them, exposes the mean.
// Only built when DIV_COLOR_CALIB_EN is defined.
`ifdef DIV_COLOR_CALIB_EN
module div_color_cal_acc #(
    parameter int C_W      = 8,
    parameter int CAL_LOG2 = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           valid,
    input  logic [C_W-1:0] r,
    input  logic [C_W-1:0] g,
    input  logic [C_W-1:0] b,
    output logic           full,
    output logic [C_W-1:0] mean_r,
    output logic [C_W-1:0] mean_g,
    output logic [C_W-1:0] mean_b
);

    localparam int A_W = C_W + CAL_LOG2;

    logic [A_W-1:0]    acc_red_r;
    logic [A_W-1:0]    acc_grn_r;
    logic [A_W-1:0]    acc_blu_r;
    logic [CAL_LOG2:0] cnt_r;

    // Sums stop growing once the count hits 2**CAL_LOG2, so no overflow is possible.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_red_r <= '0;
            acc_grn_r <= '0;
            acc_blu_r <= '0;
            cnt_r     <= '0;
        end else if (en && valid && !full) begin
            acc_red_r <= acc_red_r + {{CAL_LOG2{1'b0}}, r};
            acc_grn_r <= acc_grn_r + {{CAL_LOG2{1'b0}}, g};
            acc_blu_r <= acc_blu_r + {{CAL_LOG2{1'b0}}, b};
            cnt_r     <= cnt_r + {{CAL_LOG2{1'b0}}, 1'b1};
        end
    end

    assign full   = cnt_r[CAL_LOG2];
    assign mean_r = acc_red_r[A_W-1:CAL_LOG2];
    assign mean_g = acc_grn_r[A_W-1:CAL_LOG2];
    assign mean_b = acc_blu_r[A_W-1:CAL_LOG2];

endmodule
`endif

// File: rtl/div_color_cfg_ctrl.sv
// Threshold set owner for div_color: shadow/active double buffering with frame-aligned commit.
// Optional colour calibration is enabled by defining DIV_COLOR_CALIB_EN.
module div_color_cfg_ctrl
    import div_color_cfg_ctrl_pkg::*;
#(
    parameter int               C_W       = 8,
    parameter int               CAL_LOG2  = 6,
    parameter logic [3*C_W-1:0] DEF_A_RGB = {(3*C_W){1'b1}},
    parameter logic [3*C_W-1:0] DEF_B_RGB = {(3*C_W){1'b1}},
    parameter logic [C_W+1:0]   DEF_ERR   = (C_W+2)'(16),
    parameter logic [C_W+1:0]   DEF_VMIN  = (C_W+2)'(32),
    parameter logic [C_W+1:0]   DEF_VMAX  = {(C_W+2){1'b1}}
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic                  i_cfg_sel,
    input  logic [CFG_ADDR_W-1:0] i_cfg_addr,
    input  logic [C_W+1:0]        i_cfg_data,
    input  logic                  i_frame_start,
    input  logic                  i_valid,
    input  logic [C_W-1:0]        i_R,
    input  logic [C_W-1:0]        i_G,
    input  logic [C_W-1:0]        i_B,
    input  logic                  i_win,
    input  logic                  i_calib_start,
    output logic [C_W-1:0]        o_a_R0,
    output logic [C_W-1:0]        o_a_G0,
    output logic [C_W-1:0]        o_a_B0,
    output logic [C_W+1:0]        o_a_err,
    output logic [C_W+1:0]        o_a_Vmin,
    output logic [C_W+1:0]        o_a_Vmax,
    output logic [C_W-1:0]        o_b_R0,
    output logic [C_W-1:0]        o_b_G0,
    output logic [C_W-1:0]        o_b_B0,
    output logic [C_W+1:0]        o_b_err,
    output logic [C_W+1:0]        o_b_Vmin,
    output logic [C_W+1:0]        o_b_Vmax,
    output logic                  o_pending,
    output logic                  o_applied,
    output logic                  o_calib_done
);

    localparam int D_W = C_W + 2;

    // Index 0 = set A, 1 = set B; colour index 0/1/2 = R/G/B.
    logic [C_W-1:0] sh_rgb_r  [2][3];
    logic [C_W-1:0] act_rgb_r [2][3];
    logic [D_W-1:0] sh_err_r  [2];
    logic [D_W-1:0] sh_vmin_r [2];
    logic [D_W-1:0] sh_vmax_r [2];
    logic [D_W-1:0] act_err_r [2];
    logic [D_W-1:0] act_vmin_r[2];
    logic [D_W-1:0] act_vmax_r[2];

    logic pending_r;
    logic applied_r;
    logic cfg_ready_s;
    logic cfg_wr_s;
    logic commit_s;
    logic cal_wr_s;

    function automatic logic [C_W-1:0] def_rgb(input logic [3*C_W-1:0] v, input int idx);
        return v[(2-idx)*C_W +: C_W];
    endfunction

    assign cfg_wr_s = i_cfg_valid && cfg_ready_s;
    assign commit_s = cfg_wr_s && is_commit_addr(i_cfg_addr);

`ifdef DIV_COLOR_CALIB_EN
    cal_state_e     state_r;
    cal_state_e     state_s;
    logic           cal_sel_r;
    logic           calib_done_r;
    logic           cal_clr_s;
    logic           cal_en_s;
    logic           cal_full_s;
    logic [C_W-1:0] cal_mean_red_s;
    logic [C_W-1:0] cal_mean_grn_s;
    logic [C_W-1:0] cal_mean_blu_s;

    // Calibration state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch which set is being calibrated and register the completion pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cal_sel_r    <= 1'b0;
            calib_done_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && i_calib_start) begin
                cal_sel_r <= i_cfg_sel;
            end
            calib_done_r <= cal_wr_s;
        end
    end

    // Calibration next-state and control decode.
    always_comb begin
        state_s     = state_r;
        cal_clr_s   = 1'b0;
        cal_en_s    = 1'b0;
        cal_wr_s    = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cfg_ready_s = 1'b1;
                cal_clr_s   = 1'b1;
                if (i_calib_start) begin
                    state_s = ST_CAL_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAL_WAIT: begin
                cal_clr_s = 1'b1;
                if (i_frame_start) begin
                    state_s = ST_CAL_ACC;
                end else begin
                    state_s = ST_CAL_WAIT;
                end
            end
            ST_CAL_ACC: begin
                // A frame ending before the window yielded enough samples restarts the average.
                if (cal_full_s) begin
                    state_s = ST_CAL_WR;
                end else if (i_frame_start) begin
                    cal_clr_s = 1'b1;
                end else begin
                    cal_en_s = 1'b1;
                end
            end
            ST_CAL_WR: begin
                cal_wr_s = 1'b1;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    div_color_cal_acc #(
        .C_W      (C_W),
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal_acc (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .clr    (cal_clr_s),
        .en     (cal_en_s),
        .valid  (i_valid && i_win),
        .r      (i_R),
        .g      (i_G),
        .b      (i_B),
        .full   (cal_full_s),
        .mean_r (cal_mean_red_s),
        .mean_g (cal_mean_grn_s),
        .mean_b (cal_mean_blu_s)
    );

    assign o_calib_done = calib_done_r;
`else
    logic        unused_calib_s;
    logic [31:0] unused_cal_log2_s;

    assign cfg_ready_s       = 1'b1;
    assign cal_wr_s          = 1'b0;
    assign o_calib_done      = 1'b0;
    assign unused_calib_s    = ^{i_calib_start, i_win, i_valid, i_R, i_G, i_B};
    assign unused_cal_log2_s = 32'(CAL_LOG2);
`endif

    // Shadow registers: host writes and calibration results land here.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 3; c++) begin
                    sh_rgb_r[s][c] <= def_rgb((s == 0) ? DEF_A_RGB : DEF_B_RGB, c);
                end
                sh_err_r[s]  <= DEF_ERR;
                sh_vmin_r[s] <= DEF_VMIN;
                sh_vmax_r[s] <= DEF_VMAX;
            end
        end else begin
            if (cfg_wr_s) begin
                case (i_cfg_addr)
                    ADDR_R0:   sh_rgb_r[i_cfg_sel][0] <= i_cfg_data[C_W-1:0];
                    ADDR_G0:   sh_rgb_r[i_cfg_sel][1] <= i_cfg_data[C_W-1:0];
                    ADDR_B0:   sh_rgb_r[i_cfg_sel][2] <= i_cfg_data[C_W-1:0];
                    ADDR_ERR:  sh_err_r[i_cfg_sel]    <= i_cfg_data;
                    ADDR_VMIN: sh_vmin_r[i_cfg_sel]   <= i_cfg_data;
                    ADDR_VMAX: sh_vmax_r[i_cfg_sel]   <= i_cfg_data;
                    default: begin
                    end
                endcase
            end
`ifdef DIV_COLOR_CALIB_EN
            if (cal_wr_s) begin
                sh_rgb_r[cal_sel_r][0] <= cal_mean_red_s;
                sh_rgb_r[cal_sel_r][1] <= cal_mean_grn_s;
                sh_rgb_r[cal_sel_r][2] <= cal_mean_blu_s;
            end
`endif
        end
    end

    // Active registers: both sets are copied together, only on a frame start with a commit waiting.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 3; c++) begin
                    act_rgb_r[s][c] <= def_rgb((s == 0) ? DEF_A_RGB : DEF_B_RGB, c);
                end
                act_err_r[s]  <= DEF_ERR;
                act_vmin_r[s] <= DEF_VMIN;
                act_vmax_r[s] <= DEF_VMAX;
            end
        end else if (i_frame_start && pending_r) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 3; c++) begin
                    act_rgb_r[s][c] <= sh_rgb_r[s][c];
                end
                act_err_r[s]  <= sh_err_r[s];
                act_vmin_r[s] <= sh_vmin_r[s];
                act_vmax_r[s] <= sh_vmax_r[s];
            end
        end
    end

    // Commit bookkeeping; a commit arriving with the frame start waits for the following frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending_r <= 1'b0;
            applied_r <= 1'b0;
        end else begin
            pending_r <= commit_s || cal_wr_s || (pending_r && !i_frame_start);
            applied_r <= i_frame_start && pending_r;
        end
    end

    assign o_cfg_ready = cfg_ready_s;
    assign o_pending   = pending_r;
    assign o_applied   = applied_r;
    assign o_a_R0      = act_rgb_r[0][0];
    assign o_a_G0      = act_rgb_r[0][1];
    assign o_a_B0      = act_rgb_r[0][2];
    assign o_a_err     = act_err_r[0];
    assign o_a_Vmin    = act_vmin_r[0];
    assign o_a_Vmax    = act_vmax_r[0];
    assign o_b_R0      = act_rgb_r[1][0];
    assign o_b_G0      = act_rgb_r[1][1];
    assign o_b_B0      = act_rgb_r[1][2];
    assign o_b_err     = act_err_r[1];
    assign o_b_Vmin    = act_vmin_r[1];
    assign o_b_Vmax    = act_vmax_r[1];

endmodule
